// File: rtl/joypad_serializer.sv
// Multi-port NES joypad serializer: registers button sources, applies autofire
// and opposing-direction suppression, then latches/shifts per controller port.
module joypad_serializer #(
  parameter int unsigned C_players      = 2,
  parameter int unsigned C_bits         = 8,
  parameter int unsigned C_autofire_div = 2142857,
  parameter int unsigned C_no_opposing  = 1,
  parameter int unsigned C_fill         = 1
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          i_strobe,
  input  logic [C_players-1:0]          i_joy_clock,
  input  logic [C_players*C_bits-1:0]   i_buttons,
  input  logic [C_players*C_bits-1:0]   i_autofire_mask,
  output logic [C_players-1:0]          o_joy_data,
  output logic                          o_latched,
  output logic [C_players*4-1:0]        o_reads
);

  localparam int unsigned W      = C_players * C_bits;
  localparam int unsigned CW     = (C_autofire_div > 0) ? $clog2(C_autofire_div + 1) : 1;
  localparam int unsigned DIV_M1 = (C_autofire_div > 0) ? C_autofire_div - 1 : 0;

  logic [W-1:0]         r_btn;
  logic [W-1:0]         r_mask;
  logic [CW-1:0]        r_cnt;
  logic                 r_phase;
  logic                 r_prev_strobe;
  logic [C_players-1:0] r_prev_clk;
  logic                 r_latched;
  logic [W-1:0]         w_af;

  // Input stage, edge-detect history and latch pulse
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_btn         <= '0;
      r_mask        <= '0;
      r_prev_strobe <= 1'b0;
      r_prev_clk    <= '0;
      r_latched     <= 1'b0;
    end else begin
      r_btn         <= i_buttons;
      r_mask        <= i_autofire_mask;
      r_prev_strobe <= i_strobe;
      r_prev_clk    <= i_joy_clock;
      r_latched     <= i_strobe & ~r_prev_strobe;
    end
  end

  // Free-running autofire phase generator; a zero divider pins the phase high
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt   <= '0;
      r_phase <= 1'b1;
    end else if (C_autofire_div == 0) begin
      r_cnt   <= '0;
      r_phase <= 1'b1;
    end else if (r_cnt == CW'(DIV_M1)) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt + CW'(1);
    end
  end

  assign w_af      = r_btn & ~(r_mask & {W{~r_phase}});
  assign o_latched = r_latched;

  for (genvar p = 0; p < C_players; p++) begin : g_port
    logic [C_bits-1:0] w_af_p;
    logic [C_bits-1:0] w_eff;
    logic [C_bits-1:0] w_shifted;
    logic              w_shift;
    logic [C_bits-1:0] r_sr;
    logic [3:0]        r_rd;

    assign w_af_p  = w_af[p*C_bits +: C_bits];
    assign w_shift = r_prev_clk[p] & ~i_joy_clock[p] & ~i_strobe;

    if (C_no_opposing != 0 && C_bits >= 8) begin : g_opp
      always_comb begin
        w_eff = w_af_p;
        if (w_af_p[4] & w_af_p[5]) begin
          w_eff[4] = 1'b0;
          w_eff[5] = 1'b0;
        end
        if (w_af_p[6] & w_af_p[7]) begin
          w_eff[6] = 1'b0;
          w_eff[7] = 1'b0;
        end
      end
    end else begin : g_pass
      assign w_eff = w_af_p;
    end

    if (C_bits > 1) begin : g_wide
      assign w_shifted = {1'(C_fill), r_sr[C_bits-1:1]};
    end else begin : g_single
      assign w_shifted = 1'(C_fill);
    end

    // Strobe load has priority over a coincident falling read clock
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        r_sr <= '0;
        r_rd <= '0;
      end else if (i_strobe) begin
        r_sr <= w_eff;
        r_rd <= '0;
      end else if (w_shift) begin
        r_sr <= w_shifted;
        if (r_rd != 4'hF) r_rd <= r_rd + 4'd1;
      end
    end

    assign o_joy_data[p]       = r_sr[0];
    assign o_reads[p*4 +: 4]   = r_rd;
  end

endmodule

// File: tb/tb_joypad_serializer.sv
// Scoreboard bench for joypad_serializer: stimulus queues expected samples,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_joypad_serializer;

  localparam int S_JOY0 = 0, S_JOY1 = 1, S_RD0 = 2, S_RD1 = 3, S_LAT = 4, S_JOYB = 5;

  typedef struct {
    int          due;
    int          id;
    logic [31:0] exp;
    string       name;
  } chk_t;

  logic        clk;
  logic        resetn;
  logic        strobe;
  logic [1:0]  jclk;
  logic [15:0] btn_a;
  logic [15:0] mask_a;
  logic [7:0]  btn_b;
  logic [7:0]  mask_b;
  logic [1:0]  joy_a;
  logic        latched_a;
  logic [7:0]  reads_a;
  logic [0:0]  joy_b;
  logic        latched_b;
  logic [3:0]  reads_b;

  chk_t sb[$];
  int   gcyc = 0;
  int   rel_cyc;
  int   checks = 0;
  int   failures = 0;
  logic drain_to = 1'b0;
  logic drain_rep = 1'b0;

  joypad_serializer #(
    .C_players(2), .C_bits(8), .C_autofire_div(4), .C_no_opposing(1), .C_fill(1)
  ) dut_a (
    .clk(clk), .resetn(resetn), .i_strobe(strobe), .i_joy_clock(jclk),
    .i_buttons(btn_a), .i_autofire_mask(mask_a),
    .o_joy_data(joy_a), .o_latched(latched_a), .o_reads(reads_a)
  );

  joypad_serializer #(
    .C_players(1), .C_bits(8), .C_autofire_div(0), .C_no_opposing(0), .C_fill(1)
  ) dut_b (
    .clk(clk), .resetn(resetn), .i_strobe(strobe), .i_joy_clock(jclk[0]),
    .i_buttons(btn_b), .i_autofire_mask(mask_b),
    .o_joy_data(joy_b), .o_latched(latched_b), .o_reads(reads_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) gcyc <= gcyc + 1;

  // Cycles since reset release, used to predict the autofire phase
  always @(posedge clk or negedge resetn) begin
    if (!resetn) rel_cyc <= 0;
    else         rel_cyc <= rel_cyc + 1;
  end

  function automatic logic [31:0] observe(input int id);
    case (id)
      S_JOY0:  return 32'(joy_a[0]);
      S_JOY1:  return 32'(joy_a[1]);
      S_RD0:   return 32'(reads_a[3:0]);
      S_RD1:   return 32'(reads_a[7:4]);
      S_LAT:   return 32'(latched_a);
      S_JOYB:  return 32'(joy_b[0]);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: compare every queued expectation whose sample cycle has arrived
  always @(negedge clk) begin
    chk_t        c;
    logic [31:0] got;
    while (sb.size() > 0 && sb[0].due <= gcyc) begin
      c   = sb.pop_front();
      got = observe(c.id);
      checks++;
      if (c.due != gcyc) begin
        failures++;
        $display("FAIL %s sample missed: due cycle %0d, now %0d", c.name, c.due, gcyc);
      end else if (got !== c.exp) begin
        failures++;
        $display("FAIL %s got=%0h expected=%0h (cycle %0d)", c.name, got, c.exp, gcyc);
      end
    end
    if (drain_to && !drain_rep) begin
      drain_rep = 1'b1;
      checks++;
      failures++;
      $display("FAIL drain: %0d expectations never sampled", sb.size());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input string nm, input int id, input logic [31:0] ev);
    chk_t c;
    c.due  = gcyc;
    c.id   = id;
    c.exp  = ev;
    c.name = nm;
    sb.push_back(c);
  endtask

  task automatic pulse(input logic [1:0] m);
    jclk = jclk | m;
    step();
    jclk = jclk & ~m;
    step();
  endtask

  task automatic strobe_n(input int n);
    strobe = 1'b1;
    repeat (n) step();
    strobe = 1'b0;
    step();
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sb.size() > 0; i++) step();
    if (sb.size() > 0) drain_to = 1'b1;
  endtask

  initial begin
    logic [7:0] v;
    resetn = 1'b0;
    strobe = 1'b0;
    jclk   = '0;
    btn_a  = '0;
    mask_a = '0;
    btn_b  = '0;
    mask_b = '0;
    step();
    expect_v("rst_joy0", S_JOY0, 0);
    expect_v("rst_rd0",  S_RD0,  0);
    expect_v("rst_lat",  S_LAT,  0);
    step();
    resetn = 1'b1;
    step();

    // Port0 A+start, port1 right; read port0 ten times
    btn_a = {8'h80, 8'h09};
    strobe_n(3);
    v = 8'h09;
    for (int i = 0; i < 10; i++) begin
      expect_v($sformatf("t1_joy0[%0d]", i), S_JOY0, (i < 8) ? 32'(v[i]) : 32'd1);
      expect_v($sformatf("t1_rd0[%0d]", i),  S_RD0,  32'(i));
      pulse(2'b01);
    end
    expect_v("t1_rd0_end", S_RD0,  10);
    expect_v("t1_rd1_end", S_RD1,  0);
    expect_v("t1_joy1",    S_JOY1, 0);

    // Port1 read alone; port0 stays at its freshly latched value
    strobe_n(3);
    expect_v("t2_rd0", S_RD0, 0);
    v = 8'h80;
    for (int i = 0; i < 8; i++) begin
      expect_v($sformatf("t2_joy1[%0d]", i), S_JOY1, 32'(v[i]));
      pulse(2'b10);
    end
    expect_v("t2_rd1_end",  S_RD1,  8);
    expect_v("t2_joy1_fill", S_JOY1, 1);
    expect_v("t2_joy0",     S_JOY0, 1);
    expect_v("t2_rd0_end",  S_RD0,  0);

    // All four directions: suppressed on dut_a, passed through on dut_b
    btn_a = {8'h80, 8'hF0};
    btn_b = 8'hF0;
    strobe_n(3);
    v = 8'hF0;
    for (int i = 0; i < 8; i++) begin
      expect_v($sformatf("t3_joy0[%0d]", i), S_JOY0, 0);
      expect_v($sformatf("t3_joyb[%0d]", i), S_JOYB, 32'(v[i]));
      pulse(2'b01);
    end

    // Autofire on A with strobe held: output follows the 4-cycle phase
    btn_a  = {8'h00, 8'h01};
    mask_a = {8'h00, 8'h01};
    strobe = 1'b1;
    repeat (3) step();
    for (int i = 0; i < 16; i++) begin
      expect_v($sformatf("t4_af[%0d]", i), S_JOY0, (((rel_cyc - 1) / 4) % 2 == 0) ? 32'd1 : 32'd0);
      step();
    end
    mask_a = '0;
    repeat (2) step();
    for (int i = 0; i < 8; i++) begin
      expect_v($sformatf("t4_nomask[%0d]", i), S_JOY0, 1);
      step();
    end
    strobe = 1'b0;
    step();

    // Strobe rising on the same edge as a port0 falling clock
    btn_a = {8'h00, 8'h02};
    repeat (2) step();
    pulse(2'b01);
    pulse(2'b01);
    expect_v("t5_rd0_pre", S_RD0, 2);
    jclk = 2'b01;
    step();
    expect_v("t5_lat_pre", S_LAT, 0);
    jclk   = 2'b00;
    strobe = 1'b1;
    step();
    expect_v("t5_rd0",  S_RD0,  0);
    expect_v("t5_lat",  S_LAT,  1);
    expect_v("t5_joy0", S_JOY0, 0);
    for (int i = 0; i < 19; i++) begin
      step();
      expect_v($sformatf("t5_lat_hold[%0d]", i), S_LAT, 0);
    end
    strobe = 1'b0;
    step();

    // Reset in the middle of a read sequence
    btn_a = {8'h00, 8'hFF};
    step();
    strobe_n(3);
    for (int i = 0; i < 3; i++) pulse(2'b01);
    expect_v("t6_joy0_pre", S_JOY0, 1);
    expect_v("t6_rd0_pre",  S_RD0,  3);
    drain();
    resetn = 1'b0;
    #1;
    expect_v("t6_joy0_rst", S_JOY0, 0);
    expect_v("t6_rd0_rst",  S_RD0,  0);
    step();
    step();
    resetn = 1'b1;
    step();
    expect_v("t6_joy0_rel", S_JOY0, 0);
    for (int k = 1; k <= 9; k++) begin
      pulse(2'b01);
      expect_v($sformatf("t6_joy0[%0d]", k), S_JOY0, (k >= 8) ? 32'd1 : 32'd0);
      expect_v($sformatf("t6_rd0[%0d]", k),  S_RD0,  32'(k));
    end

    drain();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
